// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//
// Purpose:
//   Shares one Wishbone system bus (address switch + ROM/Tube/SRAM slaves)
//   between two masters: m0 (the A23 core) and m1 (DMA / host access).
//   Ownership is granted for a whole bus cycle (CYC high) and is returned
//   through one IDLE cycle before the next owner is chosen. A per-access
//   watchdog answers ERR to the owner when a slave never acknowledges.
//
// Handshake (Wishbone classic):
//   A master holds CYC for as long as it wants the bus. A transfer is
//   presented while STB is high and completes in the cycle the slave raises
//   ACK, or in the cycle the arbiter raises ERR. ACK and ERR are never high
//   together, and a master that is not the owner never sees either.
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   m0_* / m1_*                master-side Wishbone ports (adr/dat/sel/we/
//                              cyc/stb in, dat/ack/err out)
//   s_*                        shared Wishbone port towards the switch
//   grant_o                    one-hot current owner (01 = m0, 10 = m1,
//                              00 = IDLE); doubles as the FSM state view
//
// Parameters:
//   AW, DW     address / data width, SEL width is DW/8
//   TIMEOUT    cycles STB may stay unacknowledged before ERR (2..65535)
//   FIXED_PRI  1 = m0 wins every tie, 0 = round-robin
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255,
  parameter int FIXED_PRI = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;       // master granted most recently: 0 = m0, 1 = m1
  logic        w_last_nxt;
  logic [15:0] r_wd_cnt;
  logic        r_err;        // high for the single ERR cycle
  logic        w_own0;
  logic        w_own1;
  logic        w_stb_sel;
  logic        w_ack_ok;
  logic        w_wd_count;
  logic        w_wd_fire;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;       // pretend m1 went last so m0 wins the first tie
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Arbitration only happens in IDLE, so every handover
  // passes through exactly one IDLE cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        // m0 takes the bus when alone, under fixed priority, or when m1 was
        // the last owner in round-robin mode.
        if (m0_cyc_i && (!m1_cyc_i || (FIXED_PRI != 0) || r_last)) begin
          w_state_nxt = ST_OWN0;
          w_last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_OWN1;
          w_last_nxt  = 1'b1;
        end
      end
      ST_OWN0: if (!m0_cyc_i) w_state_nxt = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus muxing, purely from the registered owner so no request can glitch
  // onto the shared bus before it has been granted.
  // ---------------------------------------------------------------------------
  assign w_own0  = (r_state == ST_OWN0);
  assign w_own1  = (r_state == ST_OWN1);
  assign grant_o = {w_own1, w_own0};

  assign s_adr_o = w_own0 ? m0_adr_i : (w_own1 ? m1_adr_i : '0);
  assign s_dat_o = w_own0 ? m0_dat_i : (w_own1 ? m1_dat_i : '0);
  assign s_sel_o = w_own0 ? m0_sel_i : (w_own1 ? m1_sel_i : '0);
  assign s_we_o  = (w_own0 & m0_we_i)  | (w_own1 & m1_we_i);
  assign s_cyc_o = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);

  // STB is withdrawn during the ERR cycle so the slave sees the access end.
  assign w_stb_sel = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
  assign s_stb_o   = w_stb_sel & ~r_err;

  // A late ACK landing in the ERR cycle is dropped so ACK and ERR never pair.
  assign w_ack_ok = s_ack_i & ~r_err;

  assign m0_ack_o = w_own0 & w_ack_ok;
  assign m1_ack_o = w_own1 & w_ack_ok;
  assign m0_err_o = w_own0 & r_err;
  assign m1_err_o = w_own1 & r_err;
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;

  // ---------------------------------------------------------------------------
  // Watchdog. Counts only while a strobe is outstanding, so STB gaps inside a
  // locked cycle do not age the access. If the owner drops CYC in the very
  // cycle the watchdog fires, the FSM is already heading to IDLE and the ERR
  // pulse is masked by the ownership gating above.
  // ---------------------------------------------------------------------------
  assign w_wd_count = s_cyc_o & s_stb_o & ~s_ack_i;
  assign w_wd_fire  = w_wd_count & (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_wd_fire;
      if ((r_state == ST_IDLE) || s_ack_i || r_err || w_wd_fire) begin
        r_wd_cnt <= '0;
      end else if (w_wd_count) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [31:0] S_DAT  = 32'hE59FF018;
  localparam logic [31:0] M0_ADR = 32'h0000_0010;
  localparam logic [31:0] M1_ADR = 32'hFFFF_0000;
  localparam logic [31:0] M0_WD  = 32'h1111_1111;
  localparam logic [31:0] M1_WD  = 32'hCAFE_F00D;
  localparam logic [3:0]  M0_SEL = 4'hF;
  localparam logic [3:0]  M1_SEL = 4'h3;

  // ---------------------------------------------------------------------------
  // Clock / reset and stimulus signals
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i, s_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic          m0_we_i, m1_we_i;
  logic          m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i;

  // Round-robin DUT outputs
  logic [DW-1:0] rr_m0_dat_o, rr_m1_dat_o, rr_s_dat_o;
  logic [AW-1:0] rr_s_adr_o;
  logic [SW-1:0] rr_s_sel_o;
  logic          rr_m0_ack_o, rr_m0_err_o, rr_m1_ack_o, rr_m1_err_o;
  logic          rr_s_we_o, rr_s_cyc_o, rr_s_stb_o;
  logic [1:0]    rr_grant_o;

  // Fixed-priority DUT outputs
  logic [DW-1:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_dat_o;
  logic [AW-1:0] fp_s_adr_o;
  logic [SW-1:0] fp_s_sel_o;
  logic          fp_m0_ack_o, fp_m0_err_o, fp_m1_ack_o, fp_m1_err_o;
  logic          fp_s_we_o, fp_s_cyc_o, fp_s_stb_o;
  logic [1:0]    fp_grant_o;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8), .FIXED_PRI(0)) dut_rr (
    .clk(clk), .rst_b(rst_b),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(rr_m0_dat_o),
    .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_ack_o(rr_m0_ack_o), .m0_err_o(rr_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(rr_m1_dat_o),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_ack_o(rr_m1_ack_o), .m1_err_o(rr_m1_err_o),
    .s_adr_o(rr_s_adr_o), .s_dat_o(rr_s_dat_o), .s_dat_i(s_dat_i),
    .s_sel_o(rr_s_sel_o), .s_we_o(rr_s_we_o), .s_cyc_o(rr_s_cyc_o),
    .s_stb_o(rr_s_stb_o), .s_ack_i(s_ack_i), .grant_o(rr_grant_o)
  );

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_b(rst_b),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(fp_m0_dat_o),
    .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i), .m0_ack_o(fp_m0_ack_o), .m0_err_o(fp_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(fp_m1_dat_o),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i), .m1_ack_o(fp_m1_ack_o), .m1_err_o(fp_m1_err_o),
    .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_dat_i(s_dat_i),
    .s_sel_o(fp_s_sel_o), .s_we_o(fp_s_we_o), .s_cyc_o(fp_s_cyc_o),
    .s_stb_o(fp_s_stb_o), .s_ack_i(s_ack_i), .grant_o(fp_grant_o)
  );

  // Packed views: ctl = {grant[1:0], s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
  logic [7:0]  rr_ctl, fp_ctl;
  logic [68:0] rr_bus, fp_bus;
  logic [63:0] rr_rd, fp_rd;
  assign rr_ctl = {rr_grant_o, rr_s_cyc_o, rr_s_stb_o, rr_m0_ack_o, rr_m0_err_o, rr_m1_ack_o, rr_m1_err_o};
  assign fp_ctl = {fp_grant_o, fp_s_cyc_o, fp_s_stb_o, fp_m0_ack_o, fp_m0_err_o, fp_m1_ack_o, fp_m1_err_o};
  assign rr_bus = {rr_s_adr_o, rr_s_dat_o, rr_s_sel_o, rr_s_we_o};
  assign fp_bus = {fp_s_adr_o, fp_s_dat_o, fp_s_sel_o, fp_s_we_o};
  assign rr_rd  = {rr_m0_dat_o, rr_m1_dat_o};
  assign fp_rd  = {fp_m0_dat_o, fp_m1_dat_o};

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected shared-bus value for a given owner (m1 always writes, m0 reads).
  function automatic logic [68:0] exp_bus(input logic [1:0] g);
    if (g == 2'b01)      return {M0_ADR, M0_WD, M0_SEL, 1'b0};
    else if (g == 2'b10) return {M1_ADR, M1_WD, M1_SEL, 1'b1};
    else                 return '0;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [1:0] g);
    return {(g[0] ? S_DAT : 32'h0), (g[1] ? S_DAT : 32'h0)};
  endfunction

  // Vector table: in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  typedef struct {
    bit         rst;
    bit         fp;
    logic [4:0] in;
    logic [7:0] ctl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit fp, input logic [4:0] in, input logic [7:0] ctl);
    vec_t v;
    v.rst = rst;
    v.fp  = fp;
    v.in  = in;
    v.ctl = ctl;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [4:0] in);
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = in;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(5'b00000);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic check_rr_all(input string name, input logic [7:0] ctl);
    check({name, " ctl"}, 128'(rr_ctl), 128'(ctl));
    check({name, " bus"}, 128'(rr_bus), 128'(exp_bus(ctl[7:6])));
    check({name, " rd"},  128'(rr_rd),  128'(exp_rd(ctl[7:6])));
  endtask

  task automatic check_fp_all(input string name, input logic [7:0] ctl);
    check({name, " ctl"}, 128'(fp_ctl), 128'(ctl));
    check({name, " bus"}, 128'(fp_bus), 128'(exp_bus(ctl[7:6])));
    check({name, " rd"},  128'(fp_rd),  128'(exp_rd(ctl[7:6])));
  endtask

  // ---------------------------------------------------------------------------
  // Global time guard
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end expected end by 200000");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  initial begin
    m0_adr_i = M0_ADR; m0_dat_i = M0_WD; m0_sel_i = M0_SEL; m0_we_i = 1'b0;
    m1_adr_i = M1_ADR; m1_dat_i = M1_WD; m1_sel_i = M1_SEL; m1_we_i = 1'b1;
    s_dat_i  = S_DAT;
    drive(5'b11111);            // everything requested while in reset

    // ---- Test 1: single m0 read, slave acks on the 3rd owned cycle
    add(1, 0, 5'b11000, 8'b00_00_0000);
    add(0, 0, 5'b11000, 8'b01_11_0000);
    add(0, 0, 5'b11000, 8'b01_11_0000);
    add(0, 0, 5'b11001, 8'b01_11_1000);
    add(0, 0, 5'b00000, 8'b01_00_0000);
    add(0, 0, 5'b00000, 8'b00_00_0000);
    // ---- Test 2: round-robin, both masters keep requesting
    for (int k = 0; k < 3; k++) begin
      add(k == 0, 0, 5'b11110, 8'b00_00_0000);
      add(0, 0, 5'b11111, 8'b01_11_1000);
      add(0, 0, 5'b00110, 8'b01_00_0000);
      add(0, 0, 5'b11110, 8'b00_00_0000);
      add(0, 0, 5'b11111, 8'b10_11_0010);
      add(0, 0, 5'b11000, 8'b10_00_0000);
    end
    // ---- Test 3: fixed priority, m1 only wins once m0 stops asking
    for (int k = 0; k < 3; k++) begin
      add(k == 0, 1, 5'b11110, 8'b00_00_0000);
      add(0, 1, 5'b11111, 8'b01_11_1000);
      add(0, 1, 5'b00110, 8'b01_00_0000);
    end
    add(0, 1, 5'b00110, 8'b00_00_0000);
    add(0, 1, 5'b00111, 8'b10_11_0010);
    add(0, 1, 5'b00000, 8'b10_00_0000);
    add(0, 1, 5'b00000, 8'b00_00_0000);
    // ---- Test 4: m1 write never acked, TIMEOUT=8; late ack in ERR cycle
    add(1, 0, 5'b00110, 8'b00_00_0000);
    for (int k = 0; k < 8; k++) add(0, 0, 5'b00110, 8'b10_11_0000);
    add(0, 0, 5'b00111, 8'b10_10_0001);
    add(0, 0, 5'b00000, 8'b10_00_0000);
    add(0, 0, 5'b00000, 8'b00_00_0000);

    // ---- Reset state: all outputs zero while rst_b is low
    repeat (2) @(negedge clk);
    #1;
    check_rr_all("reset rr", 8'h00);
    check_fp_all("reset fp", 8'h00);

    // ---- Apply the table
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      if (vecs[i].fp) check_fp_all($sformatf("vec%0d fp", i), vecs[i].ctl);
      else            check_rr_all($sformatf("vec%0d rr", i), vecs[i].ctl);
    end

    // ---- Test 5: m0 locked 4-beat cycle with long STB gaps, m1 waiting
    do_reset();
    @(negedge clk);
    drive(5'b11110);
    #1 check("t5 idle grant", 128'(rr_grant_o), 128'(2'b00));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      drive(5'b11110);
      #1 check($sformatf("t5 beat%0d wait", b), 128'(rr_ctl), 128'(8'b01_11_0000));
      @(negedge clk);
      drive(5'b11111);
      #1 check($sformatf("t5 beat%0d ack", b), 128'(rr_ctl), 128'(8'b01_11_1000));
      for (int g = 0; g < 10; g++) begin
        @(negedge clk);
        drive(5'b10110);
        #1 check($sformatf("t5 beat%0d gap%0d", b, g), 128'(rr_ctl), 128'(8'b01_10_0000));
      end
    end
    @(negedge clk);
    drive(5'b00110);
    #1 check("t5 drop grant", 128'(rr_grant_o), 128'(2'b01));
    @(negedge clk);
    #1 check("t5 handover idle", 128'(rr_grant_o), 128'(2'b00));
    @(negedge clk);
    #1 check("t5 m1 granted", 128'(rr_grant_o), 128'(2'b10));

    // ---- Test 6: asynchronous reset in the middle of an m1 access
    do_reset();
    @(negedge clk);
    drive(5'b00110);
    @(negedge clk);
    drive(5'b00111);
    #1 check_rr_all("t6 pre-reset", 8'b10_11_0010);
    #2 rst_b = 1'b0;
    #1 check_rr_all("t6 async reset", 8'h00);
    @(negedge clk);
    drive(5'b11110);
    @(negedge clk);
    rst_b = 1'b1;
    #1 check("t6 released idle", 128'(rr_grant_o), 128'(2'b00));
    @(negedge clk);
    #1;
    check("t6 rr first grant", 128'(rr_grant_o), 128'(2'b01));
    check("t6 fp first grant", 128'(fp_grant_o), 128'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master Wishbone arbiter that shares the single system bus between the A23 core (m0) and a second master (m1), such as a DMA or host-access engine.
- The bus comprises the address-decoding switch plus ROM, Tube and SRAM slaves.
- Ownership is granted per bus cycle (whole CYC assertion), with round-robin or fixed priority.
- A per-access watchdog returns ERR to the owner if a slave never acknowledges.

Parameters:
AW, 32, address width.
DW, 32, data width; SEL width is DW/8.
TIMEOUT, 255, cycles STB may remain unacknowledged before ERR is returned; legal range 2..65535.
FIXED_PRI, 0, 1 = m0 always wins simultaneous requests; 0 = round-robin.

Ports:
clk  in  1  system clock
rst_b  in  1  asynchronous active-low reset
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_dat_o  out  DW  master 0 read data
m0_sel_i  in  DW/8  master 0 byte selects
m0_we_i  in  1  master 0 write enable
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_ack_o  out  1  master 0 acknowledge
m0_err_o  out  1  master 0 error (timeout)
m1_*  -  -  identical set for master 1
s_adr_o  out  AW  to switch
s_dat_o  out  DW  to switch
s_dat_i  in  DW  from switch
s_sel_o  out  DW/8  to switch
s_we_o  out  1  to switch
s_cyc_o  out  1  to switch
s_stb_o  out  1  to switch
s_ack_i  in  1  from switch
grant_o  out  2  one-hot current owner, for debug/test header

Behaviour:
- State machine, registered: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high: FIXED_PRI=1 -> OWN0; FIXED_PRI=0 -> the master not recorded in last_reg.
  - last_reg updates on every grant.
- OWNn: stay while mn_cyc_i is high. mn_cyc_i low -> IDLE. There is always exactly one IDLE cycle between owners; no back-to-back handover.
- Latency: a request first sampled in IDLE is visible on s_cyc_o one clk later. A single access therefore costs 1 cycle + slave latency.
- Muxing (combinational from the registered state):
  - In OWNn, s_* outputs = mn_* inputs.
  - mn_ack_o = s_ack_i; mn_dat_o = s_dat_i.
  - The non-owner sees ack=0, err=0, dat_o=0.
  - In IDLE, all s_* outputs are 0 and grant_o=00.
- The non-owner may hold CYC/STB indefinitely; it is never acked and never loses its pending request.
- Watchdog:
  - 16-bit wd_cnt increments each cycle with s_cyc_o & s_stb_o & !s_ack_i.
  - Clears on s_ack_i, in IDLE, and on ERR.
  - When wd_cnt == TIMEOUT-1 and no ack that cycle: registered mn_err_o pulses for exactly 1 cycle; s_stb_o is forced low during that ERR cycle.
  - ack and err are never simultaneously high.
  - A late ack arriving in the ERR cycle is discarded.
- Owner drops CYC in the same cycle as ack: legal; the next state is IDLE.
- STB low with CYC high (idle within a locked cycle): ownership is kept and the watchdog does not count.
- Reset (rst_b low, any time, including mid-access):
  - State -> IDLE, last_reg -> m1 (so m0 wins the first tie), wd_cnt -> 0.
  - All outputs 0: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m*_ack_o, m*_err_o, m*_dat_o, grant_o.
  - Release is synchronous to the first clk edge after rst_b rises.

Test Plan:
1. Reset, then m0 issues a single read to 0x00000010, slave acks after 2 cycles with 0xE59FF018 -> grant_o=01 one cycle after request; m0_dat_o=0xE59FF018 with m0_ack_o; m1_ack_o stays 0; IDLE after m0 CYC drops.
2. FIXED_PRI=0, both masters hold CYC continuously with 3 single-cycle-ack accesses each -> grants alternate OWN0, IDLE, OWN1, IDLE, OWN0…, m0 first after reset; no master starves.
3. FIXED_PRI=1, same stimulus -> m0 owns every tie; m1 is granted only in an IDLE where m0_cyc_i is low.
4. TIMEOUT=8, m1 write to unmapped address, slave never acks -> m1_err_o high for exactly 1 cycle, 8 cycles after s_stb_o first high; s_stb_o low that cycle; m1 drops CYC -> IDLE.
5. m0 holds a 4-beat CYC (STB gaps between beats) while m1 requests -> m1 is not granted until m0 CYC falls; watchdog never fires during STB gaps.
6. Assert rst_b low mid-access while OWN1 with STB high -> all outputs 0 immediately (asynchronously); after release with both requesting, m0 granted first.
